// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit, also consumed by the decoder and hazard unit.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FINISH = 2'b10
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, subtract the divisor if it fits.
module mult_div_unit_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[DATA_W];
        // When the subtraction borrows, shifted < divisor, so it still fits in DATA_W bits.
        rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers; one magnitude iteration per cycle,
// sign fix-up presented in the FINISH cycle and committed to HI/LO at its closing edge.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [2*DATA_W-1:0] acc_q, acc_d;        // {hi part, lo part}: product or {remainder, quotient}
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    op_e                 op_in;
    logic                accept;
    logic                finishing;
    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   div_rem;
    logic                div_q_bit;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   quot, rem;
    logic [DATA_W-1:0]   res_hi, res_lo;

    mult_div_unit_div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem_in       (acc_q[2*DATA_W-1:DATA_W]),
        .dividend_bit (acc_q[DATA_W-1]),
        .divisor      (opnd_q),
        .rem_out      (div_rem),
        .q_bit        (div_q_bit)
    );

    assign busy      = (state_q == S_RUN);
    assign accept    = start && !busy && !flush;
    assign finishing = (state_q == S_FINISH) && !flush;
    assign done      = finishing;
    assign hi        = finishing ? res_hi : hi_q;
    assign lo        = finishing ? res_lo : lo_q;

    always_comb begin
        op_in   = op_e'(op);
        a_neg   = op_is_signed(op_in) && operand_a[DATA_W-1];
        b_neg   = op_is_signed(op_in) && operand_b[DATA_W-1];
        a_mag   = a_neg ? -operand_a : operand_a;
        b_mag   = b_neg ? -operand_b : operand_b;
        mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
    end

    always_comb begin
        product = neg_lo_q ? -acc_q : acc_q;
        quot    = acc_q[DATA_W-1:0];
        rem     = acc_q[2*DATA_W-1:DATA_W];
        if (op_is_div(op_q)) begin
            // Divide by zero leaves quotient all ones and remainder = |a|; the dividend sign restores a.
            res_lo = (opnd_q == '0) ? {DATA_W{1'b1}} : (neg_lo_q ? -quot : quot);
            res_hi = neg_hi_q ? -rem : rem;
        end else begin
            res_lo = product[DATA_W-1:0];
            res_hi = product[2*DATA_W-1:DATA_W];
        end
    end

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_is_div(op_q)) begin
                        acc_d = {div_rem, acc_q[DATA_W-2:0], div_q_bit};
                    end else begin
                        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // IDLE and FINISH both accept a new operation; FINISH enables back-to-back issue.
        if (accept) begin
            state_d  = S_RUN;
            op_d     = op_in;
            cnt_d    = CNT_W'(DATA_W);
            neg_lo_d = a_neg ^ b_neg;
            if (op_is_div(op_in)) begin
                opnd_d   = b_mag;
                acc_d    = {{DATA_W{1'b0}}, a_mag};
                neg_hi_d = a_neg;
            end else begin
                opnd_d   = a_mag;
                acc_d    = {{DATA_W{1'b0}}, b_mag};
                neg_hi_d = 1'b0;
            end
        end

        if (finishing) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (!busy) begin
            if (hi_we) hi_d = wr_data;
            if (lo_we) lo_d = wr_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MULT;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: results, latency, flush, MTHI/MTLO and reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        flush;
    logic        hi_we, lo_we;
    logic [31:0] wr_data;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total  = 0;
    int passed = 0;

    mult_div_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and returns at the first cycle with done high (cycles = edges counted
    // from the accepting edge), or after a 40-edge budget with cycles = 0.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output logic busy_seen);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        cycles = 0; busy_seen = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) begin
                start = 1'b0;
                busy_seen = busy;
            end
            if (done) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {busy, done}); else passed++;
        total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); else passed++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int cyc; logic bs;
        tick();
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, cyc, bs);
        total++; if (cyc !== 33) $display("FAIL mult_latency: got %0d expected 33", cyc); else passed++;
        total++; if (bs !== 1'b1) $display("FAIL mult_busy: got %b expected 1", bs); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mult_busy_done_cycle: got %b expected 0", busy); else passed++;
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL mult_result: got %h expected FFFFFFFFFFFFFFEB", {hi, lo}); else passed++;
        tick();
        total++; if ({done, hi, lo} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFEB}) $display("FAIL mult_hold: got %h expected 0FFFFFFFFFFFFFFEB", {done, hi, lo}); else passed++;
    endtask

    task automatic test_multu();
        int cyc; logic bs;
        tick();
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bs);
        total++; if (cyc !== 33) $display("FAIL multu_latency: got %0d expected 33", cyc); else passed++;
        total++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_result: got %h expected FFFFFFFE00000001", {hi, lo}); else passed++;
    endtask

    task automatic test_div();
        int cyc; logic bs;
        tick();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, bs);
        total++; if (cyc !== 33) $display("FAIL div_latency: got %0d expected 33", cyc); else passed++;
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_result: got %h expected FFFFFFFFFFFFFFFD", {hi, lo}); else passed++;
        tick();
        run_op(2'b11, 32'd100, 32'd7, cyc, bs);
        total++; if ({hi, lo} !== 64'h0000_0002_0000_000E) $display("FAIL divu_result: got %h expected 000000020000000E", {hi, lo}); else passed++;
    endtask

    task automatic test_div_corners();
        int cyc; logic bs;
        tick();
        run_op(2'b11, 32'd5, 32'd0, cyc, bs);
        total++; if (cyc !== 33) $display("FAIL divu_zero_latency: got %0d expected 33", cyc); else passed++;
        total++; if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) $display("FAIL divu_zero: got %h expected 00000005FFFFFFFF", {hi, lo}); else passed++;
        tick();
        run_op(2'b10, 32'hFFFF_FFF6, 32'd0, cyc, bs);
        total++; if ({hi, lo} !== 64'hFFFF_FFF6_FFFF_FFFF) $display("FAIL div_zero_neg: got %h expected FFFFFFF6FFFFFFFF", {hi, lo}); else passed++;
        tick();
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bs);
        total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) $display("FAIL div_overflow: got %h expected 0000000080000000", {hi, lo}); else passed++;
    endtask

    task automatic test_mthi();
        int cyc; logic bs;
        tick();
        hi_we = 1'b1; wr_data = 32'h1234_5678;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h8765_4321;
        tick();
        lo_we = 1'b0;
        total++; if ({hi, lo} !== 64'h1234_5678_8765_4321) $display("FAIL mthi_mtlo: got %h expected 1234567887654321", {hi, lo}); else passed++;
        // A result write in the done cycle must beat a concurrent MTHI/MTLO.
        run_op(2'b01, 32'd2, 32'd3, cyc, bs);
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hDEAD_BEEF;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        total++; if ({hi, lo} !== 64'h0000_0000_0000_0006) $display("FAIL finish_priority: got %h expected 0000000000000006", {hi, lo}); else passed++;
    endtask

    task automatic test_start_while_busy();
        int cyc = 0;
        tick();
        start = 1'b1; op = 2'b01; operand_a = 32'd9; operand_b = 32'd11;
        for (int n = 1; n <= 40; n++) begin
            tick();
            start = (n == 5);
            op = 2'b11; operand_a = 32'd100; operand_b = 32'd7;
            if (done) begin
                cyc = n;
                break;
            end
        end
        start = 1'b0;
        total++; if (cyc !== 33) $display("FAIL busy_start_latency: got %0d expected 33", cyc); else passed++;
        total++; if ({hi, lo} !== 64'h0000_0000_0000_0063) $display("FAIL busy_start_result: got %h expected 0000000000000063", {hi, lo}); else passed++;
        tick();
        tick();
        total++; if (busy !== 1'b0) $display("FAIL busy_start_not_queued: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_flush();
        int dones = 0;
        tick();
        hi_we = 1'b1; lo_we = 1'b0; wr_data = 32'hAAAA_5555;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h0F0F_0F0F;
        tick();
        lo_we = 1'b0;
        start = 1'b1; op = 2'b01; operand_a = 32'd6; operand_b = 32'd7;
        for (int n = 1; n <= 10; n++) begin
            tick();
            start = 1'b0;
        end
        total++; if (busy !== 1'b1) $display("FAIL flush_pre_busy: got %b expected 1", busy); else passed++;
        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy); else passed++;
        for (int n = 0; n < 40; n++) begin
            if (done) dones++;
            tick();
        end
        total++; if (dones !== 0) $display("FAIL flush_no_done: got %0d expected 0", dones); else passed++;
        total++; if ({hi, lo} !== 64'hAAAA_5555_0F0F_0F0F) $display("FAIL flush_hilo: got %h expected AAAA55550F0F0F0F", {hi, lo}); else passed++;
    endtask

    task automatic test_reset_mid();
        tick();
        start = 1'b1; op = 2'b10; operand_a = 32'd1000; operand_b = 32'd3;
        for (int n = 1; n <= 10; n++) begin
            tick();
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done} !== 2'b00) $display("FAIL reset_mid_flags: got %b expected 00", {busy, done}); else passed++;
        total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_mid_hilo: got %h expected 0", {hi, lo}); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc; logic bs;
        int cyc2 = 0;
        tick();
        run_op(2'b01, 32'd3, 32'd5, cyc, bs);
        total++; if ({cyc, hi, lo} !== {32'd33, 64'h0000_0000_0000_000F}) $display("FAIL b2b_first: got %0d %h expected 33 000000000000000F", cyc, {hi, lo}); else passed++;
        start = 1'b1; op = 2'b11; operand_a = 32'd100; operand_b = 32'd7;
        for (int n = 1; n <= 40; n++) begin
            tick();
            start = 1'b0;
            if (done) begin
                cyc2 = n;
                break;
            end
        end
        total++; if (cyc2 !== 33) $display("FAIL b2b_latency: got %0d expected 33", cyc2); else passed++;
        total++; if ({hi, lo} !== 64'h0000_0002_0000_000E) $display("FAIL b2b_second: got %h expected 000000020000000E", {hi, lo}); else passed++;
        tick();
    endtask

    initial begin
        start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_corners();
        test_mthi();
        test_start_while_busy();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
